instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch front end between the memController instruction port and the CPU decode stage.
- Drives the 14-bit word address `instr_addr` and captures the 16-bit `instr_data`, which the memController returns one cycle after the address is presented.
- Buffers fetched words with their PCs in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Supports branch redirect with flush of queued and in-flight words.

Parameters:
- RESET_PC, 14'h0000, word address fetched first after reset.
- DEPTH, 4, prefetch FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  fetch enable; low stops new fetch issue.
- instr_addr  output  14  word address to memController instruction port.
- instr_data  input  16  memory read data for the address presented in the previous cycle.
- redirect  input  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  input  14  redirect target word address.
- instr_valid  output  1  FIFO head valid.
- instr_out  output  16  FIFO head instruction word.
- instr_pc  output  14  word address of instr_out.
- instr_ready  input  1  decode accepts the head this cycle.
- stall_count  output  16  fetch-starvation counter (see Optional Feature).

Behaviour:
- `instr_addr` is driven directly from the fetch_pc register (no combinational path from inputs).
- Reset (synchronous, sampled on a clk edge while reset=1):
  - fetch_pc=RESET_PC; FIFO empty; inflight=0; stall_count=0.
  - instr_valid=0; instr_out=0; instr_pc=0 when empty.
- Issue condition, evaluated each cycle: enable=1, redirect=0, and (count + inflight) < DEPTH.
  - The pop in the current cycle is not credited.
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1. Otherwise inflight<=0.
- Wrap: fetch_pc increments modulo 2^14 (14'h3FFF -> 14'h0000).
- Response: while inflight=1 and redirect=0, {instr_data, inflight_pc} is written to the FIFO tail at the edge ending that cycle.
  - Capacity accounting guarantees the FIFO is never written while full.
  - Writing to a full FIFO is a design error; the bench asserts it never happens.
- Pop: instr_valid && instr_ready removes the head at the clock edge.
  - Push and pop in the same cycle are both performed; count is unchanged.
- Output view: instr_valid is high whenever count > 0; instr_out/instr_pc show the head entry.
  - Words appear one cycle after capture; no bypass from instr_data to instr_out.
- Latency: address issued in cycle N -> data captured end of N+1 -> instr_valid with that word in N+2.
  - Back-to-back issue gives a sustained throughput of 1 word/cycle while decode is ready.
- Redirect (priority over issue, capture and pop in the same cycle):
  - FIFO flushed (count=0); any inflight response dropped; no issue that cycle.
  - fetch_pc<=redirect_pc; a pop in that cycle is discarded.
  - First fetch at redirect_pc is issued in cycle N+1; its instr_valid follows in N+3.
- enable=0:
  - No new issues; fetch_pc holds.
  - An already-inflight response is still captured; the FIFO still drains to decode.
  - Redirect is still honoured.
- Reset during any activity overrides everything, including redirect; all state is cleared at that edge.
- Ordering: words leave in issue order; instr_pc of consecutive words without redirect differs by +1 (mod 2^14).

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - stall_count increments each cycle where enable=1, instr_valid=0 and reset=0.
  - Saturates at 16'hFFFF; cleared by reset; not cleared by redirect.
- Undefined: the stall_count port remains and is tied to 16'h0000; no counter logic is present.

Test Plan:
- Reset release, enable=1, instr_ready=1, memory word = address^16'hA5A5 -> instr_addr 0,1,2,... each cycle; first instr_valid two cycles after first issue with instr_pc=0, instr_out=16'hA5A5; then one word per cycle in order.
- instr_ready=0 from start -> exactly 4 issues (addresses 0..3), instr_addr then holds 4; FIFO holds PCs 0..3. Raise ready -> PCs 0,1,2,3,4,... with no gaps or duplicates.
- Redirect to 14'h0100 while FIFO holds 3 words and one fetch is inflight -> next cycle instr_valid=0, instr_addr=14'h0100; first valid word has instr_pc=14'h0100; no pre-redirect PCs ever appear after the redirect.
- RESET_PC=14'h3FFE, free-running -> instr_pc sequence 3FFE, 3FFF, 0000, 0001.
- Drop enable for 5 cycles mid-stream with ready=1 -> inflight word still delivered, then instr_valid falls, instr_addr holds. With FETCH_STATS_EN, stall_count counts only cycles where enable=1 and instr_valid=0 (here +0 during the enable-low window), and reads 16'h0000 without the macro.
- Assert reset for one cycle mid-stream coincident with redirect -> next cycle instr_valid=0, instr_addr=RESET_PC, stall_count=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch front end.
// Issues word addresses to the memory instruction port, captures the returned
// data one cycle later into a small prefetch FIFO, and presents the head entry
// to decode over a valid/ready handshake. A redirect flushes queued and
// in-flight words and restarts fetch at a new PC.
// Optional feature macro: FETCH_STATS_EN (fetch-starvation counter on stall_count).
module instr_fetch_unit #(
  parameter logic [13:0] RESET_PC = 14'h0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [13:0] instr_addr,
  input  logic [15:0] instr_data,
  input  logic        redirect,
  input  logic [13:0] redirect_pc,
  output logic        instr_valid,
  output logic [15:0] instr_out,
  output logic [13:0] instr_pc,
  input  logic        instr_ready,
  output logic [15:0] stall_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [13:0]   fetch_pc_q,    fetch_pc_d;
  logic          inflight_q,    inflight_d;
  logic [13:0]   inflight_pc_q, inflight_pc_d;
  logic [PW-1:0] wr_ptr_q,      wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,      rd_ptr_d;
  logic [CW-1:0] count_q,       count_d;
  logic [15:0]   data_mem_q [DEPTH];
  logic [13:0]   pc_mem_q   [DEPTH];

  logic          issue_s;
  logic          push_s;
  logic          pop_s;
  logic          not_empty_s;
  logic [CW:0]   occupancy_s;

  assign not_empty_s = (count_q != {CW{1'b0}});
  // Pops in the current cycle are not credited, so capacity is count plus in-flight.
  assign occupancy_s = (CW + 1)'(count_q) + (CW + 1)'(inflight_q);

  // Next-state logic for fetch PC, in-flight tracking and FIFO pointers/count.
  always_comb begin
    issue_s       = enable && !redirect && (occupancy_s < DEPTH_W);
    push_s        = inflight_q && !redirect;
    pop_s         = not_empty_s && instr_ready && !redirect;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (redirect) begin
      // Flush everything; the first fetch at the target issues next cycle.
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      count_d    = {CW{1'b0}};
    end else begin
      if (issue_s) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 14'd1;
      end else begin
        inflight_d = 1'b0;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 14'h0000;
      wr_ptr_q      <= {PW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      count_q       <= {CW{1'b0}};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage: capture the returning word with its PC at the tail.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      data_mem_q[wr_ptr_q] <= instr_data;
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  assign instr_addr  = fetch_pc_q;
  assign instr_valid = not_empty_s;
  assign instr_out   = not_empty_s ? data_mem_q[rd_ptr_q] : 16'h0000;
  assign instr_pc    = not_empty_s ? pc_mem_q[rd_ptr_q]   : 14'h0000;

`ifdef FETCH_STATS_EN
  logic [15:0] stall_q, stall_d;

  // Starvation counter: cycles where fetch is enabled but decode has nothing.
  always_comb begin
    stall_d = stall_q;
    if (enable && !not_empty_s && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Starvation counter register; survives redirect, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 16'h0000;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scoreboard of expected {pc,data}
// words popped by a monitor on every decode handshake, plus directed checks
// of addresses, latency, redirect, enable gating, reset and PC wrap.
module tb_instr_fetch_unit;

`ifdef FETCH_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [13:0] instr_addr;
  logic [15:0] instr_data = 16'h0000;
  logic        redirect = 1'b0;
  logic [13:0] redirect_pc = 14'h0000;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic [13:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [15:0] stall_count;

  // second instance exercising PC wrap, free running
  logic        w_enable = 1'b1;
  logic        w_redirect = 1'b0;
  logic [13:0] w_redirect_pc = 14'h0000;
  logic        w_ready = 1'b1;
  logic [13:0] w_addr;
  logic [15:0] w_data = 16'h0000;
  logic        w_valid;
  logic [15:0] w_out;
  logic [13:0] w_pc;
  logic [15:0] w_stall;

  int checks = 0;
  int errors = 0;
  int n_pops = 0;

  typedef struct packed {
    logic [13:0] pc;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [13:0] w_exp = 14'h3FFE;
  logic [13:0] wrap_tbl [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(14'h0000), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .instr_addr(instr_addr),
    .instr_data(instr_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .stall_count(stall_count)
  );

  instr_fetch_unit #(.RESET_PC(14'h3FFE), .DEPTH(4)) dut_w (
    .clk(clk), .reset(reset), .enable(w_enable), .instr_addr(w_addr),
    .instr_data(w_data), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .instr_valid(w_valid), .instr_out(w_out), .instr_pc(w_pc),
    .instr_ready(w_ready), .stall_count(w_stall)
  );

  // memory models: word = address ^ A5A5, returned one cycle after the address
  always @(posedge clk) begin
    instr_data <= {2'b00, instr_addr} ^ 16'hA5A5;
    w_data     <= {2'b00, w_addr} ^ 16'hA5A5;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [13:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [13:0] p;
      p = start + 14'(i);
      exp_q.push_back({p, {2'b00, p} ^ 16'hA5A5});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    exp_q.delete();
    tick();
    tick();
    n_pops = 0;
  endtask

  // scoreboard monitor for the main instance
  always @(negedge clk) begin
    if (!reset && !redirect && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got pc %0h expected no word", instr_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_pc", 32'(instr_pc), 32'(mon_e.pc));
        chk("sb_data", 32'(instr_out), 32'(mon_e.data));
      end
      n_pops++;
    end
  end

  // running-PC monitor for the wrap instance
  always @(negedge clk) begin
    if (reset) begin
      w_exp = 14'h3FFE;
    end else if (w_valid && w_ready) begin
      chk("wrap_sb_pc", 32'(w_pc), 32'(w_exp));
      chk("wrap_sb_data", 32'(w_out), 32'({2'b00, w_exp} ^ 16'hA5A5));
      w_exp = w_exp + 14'd1;
    end
  end

  // the FIFO must never be written while full
  always @(negedge clk) begin
    if (!reset && !redirect && dut.inflight_q && (int'(dut.count_q) == 4)) begin
      errors++;
      $display("FAIL fifo_full_write: got write with count 4 expected none");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state
    do_reset();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_out", 32'(instr_out), 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_addr", 32'(instr_addr), 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);

    // ---- free-running stream, latency and wrap instance
    push_seq(14'h0000, 40);
    reset = 1'b0;
    enable = 1'b1;
    instr_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) chk("t1_addr", 32'(instr_addr), 32'(c));
      if (c < 2) chk("t1_valid_lat", 32'(instr_valid), 32'd0);
      if (c == 2) begin
        chk("t1_first_valid", 32'(instr_valid), 32'd1);
        chk("t1_first_pc", 32'(instr_pc), 32'd0);
        chk("t1_first_out", 32'(instr_out), 32'hA5A5);
      end
      if (c >= 2 && c <= 5) chk("wrap_pc", 32'(w_pc), 32'(wrap_tbl[c-2]));
      tick();
    end
    chk("t1_throughput", 32'(n_pops), 32'd8);

    // ---- decode not ready: FIFO fills with exactly 4 words
    do_reset();
    push_seq(14'h0000, 40);
    reset = 1'b0;
    enable = 1'b1;
    instr_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) chk("t2_addr", 32'(instr_addr), 32'(c));
      tick();
    end
    chk("t2_addr_hold", 32'(instr_addr), 32'd4);
    chk("t2_valid", 32'(instr_valid), 32'd1);
    chk("t2_head_pc", 32'(instr_pc), 32'd0);
    chk("t2_no_pops", 32'(n_pops), 32'd0);
    instr_ready = 1'b1;
    repeat (12) tick();
    chk("t2_drain_pops", 32'(n_pops), 32'd12);

    // ---- redirect with 3 queued words and one in flight
    do_reset();
    push_seq(14'h0000, 40);
    reset = 1'b0;
    enable = 1'b1;
    instr_ready = 1'b0;
    repeat (4) tick();
    chk("t3_pre_valid", 32'(instr_valid), 32'd1);
    chk("t3_pre_addr", 32'(instr_addr), 32'd4);
    redirect = 1'b1;
    redirect_pc = 14'h0100;
    instr_ready = 1'b1;
    exp_q.delete();
    push_seq(14'h0100, 40);
    tick();
    redirect = 1'b0;
    chk("t3_flush_valid", 32'(instr_valid), 32'd0);
    chk("t3_redir_addr", 32'(instr_addr), 32'h100);
    tick();
    chk("t3_valid_n2", 32'(instr_valid), 32'd0);
    chk("t3_addr_n2", 32'(instr_addr), 32'h101);
    tick();
    chk("t3_valid_n3", 32'(instr_valid), 32'd1);
    chk("t3_first_pc", 32'(instr_pc), 32'h100);
    repeat (6) tick();
    chk("t3_pops", 32'(n_pops), 32'd6);

    // ---- enable low for 5 cycles mid-stream, starvation counter
    do_reset();
    push_seq(14'h0000, 60);
    reset = 1'b0;
    enable = 1'b1;
    instr_ready = 1'b1;
    repeat (2) tick();
    chk("t4_stall_c2", 32'(stall_count), 32'(STATS * 2));
    repeat (4) tick();
    chk("t4_stall_c6", 32'(stall_count), 32'(STATS * 2));
    enable = 1'b0;
    tick();
    chk("t4_inflight_delivered", 32'(instr_valid), 32'd1);
    tick();
    chk("t4_valid_falls", 32'(instr_valid), 32'd0);
    repeat (2) tick();
    chk("t4_valid_low", 32'(instr_valid), 32'd0);
    chk("t4_addr_hold", 32'(instr_addr), 32'd6);
    tick();
    chk("t4_stall_window", 32'(stall_count), 32'(STATS * 2));
    chk("t4_addr_resume", 32'(instr_addr), 32'd6);
    enable = 1'b1;
    repeat (2) tick();
    chk("t4_resume_valid", 32'(instr_valid), 32'd1);
    chk("t4_resume_pc", 32'(instr_pc), 32'd6);
    chk("t4_stall_after", 32'(stall_count), 32'(STATS * 4));
    repeat (3) tick();
    chk("t4_pops", 32'(n_pops), 32'd9);

    // ---- reset coincident with redirect mid-stream
    reset = 1'b1;
    redirect = 1'b1;
    redirect_pc = 14'h0200;
    exp_q.delete();
    tick();
    reset = 1'b0;
    redirect = 1'b0;
    n_pops = 0;
    push_seq(14'h0000, 40);
    chk("t5_valid", 32'(instr_valid), 32'd0);
    chk("t5_addr", 32'(instr_addr), 32'd0);
    chk("t5_stall", 32'(stall_count), 32'd0);
    repeat (4) tick();
    chk("t5_pops", 32'(n_pops), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
